// File: rtl/otbn_pq_pkg.sv
// Shared constants and types for the OTBN post-quantum loop controller.
// Control SPR address map, decoded instruction flags and counter limits.
package otbn_pq_pkg;

  localparam int unsigned XyMod   = 5;
  localparam int unsigned XyW     = 3;
  localparam int unsigned RcLimit = 24;
  localparam int unsigned RcW     = 5;
  localparam int unsigned IdxW    = 8;

  typedef enum logic [7:0] {
    PqctrlM     = 8'h00,
    PqctrlJ2    = 8'h01,
    PqctrlJ     = 8'h02,
    PqctrlIdx0  = 8'h03,
    PqctrlIdx1  = 8'h04,
    PqctrlMode  = 8'h05,
    PqctrlX     = 8'h06,
    PqctrlY     = 8'h07,
    PqctrlRcIdx = 8'h08
  } pqctrlspr_e;

  // Field order matters: the first field is the MSB of the packed vector.
  typedef struct packed {
    logic sl_m;
    logic sl_j2;
    logic inc_j;
    logic set_idx;
    logic inc_idx;
    logic inc_x;
    logic inc_y;
    logic rc_idx_inc;
    logic ictrlspr_wr_insn;
    logic ictrlspr_rs_insn;
  } insn_dec_shared_pq_t;

endpackage

// File: rtl/otbn_pq_mod_counter.sv
// Modulo counter with load priority over increment and a registered wrap pulse.
// The limit is either the Limit parameter or, with DynLimit set, the limit_i port.
module otbn_pq_mod_counter #(
  parameter int unsigned Width    = 3,
  parameter int unsigned Limit    = 5,
  parameter bit          DynLimit = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             inc_i,
  input  logic [Width-1:0] limit_i,
  output logic [Width-1:0] cnt_o,
  output logic             wrap_o
);

  logic [Width-1:0] cnt_q, cnt_d, limit;
  logic [Width:0]   inc_sum;
  logic             hit;
  logic             wrap_q, wrap_d;

  assign limit = DynLimit ? limit_i : Width'(Limit);

  // One extra bit so an all-ones count still compares correctly against the limit.
  assign inc_sum = {1'b0, cnt_q} + {{Width{1'b0}}, 1'b1};
  assign hit     = inc_sum >= {1'b0, limit};

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (inc_i) begin
      if (hit) begin
        cnt_d  = '0;
        wrap_d = 1'b1;
      end else begin
        cnt_d = inc_sum[Width-1:0];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign wrap_o = wrap_q;

endmodule

// File: rtl/otbn_pq_loop_ctrl.sv
// Loop/index control registers for OTBN post-quantum instructions.
// Updates happen only on committed instructions; explicit writes beat increments.
module otbn_pq_loop_ctrl
  import otbn_pq_pkg::*;
#(
  parameter int unsigned PqctrlW = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                commit_i,
  input  insn_dec_shared_pq_t insn_dec_shared_i,
  input  logic [7:0]          ctrl_addr_i,
  input  logic [31:0]         ctrl_wdata_i,
  output logic [31:0]         ctrl_rdata_o,
  output logic                ctrl_err_o,
  output logic [PqctrlW-1:0]  m_o,
  output logic [PqctrlW-1:0]  j2_o,
  output logic [PqctrlW-1:0]  j_o,
  output logic [PqctrlW-1:0]  mode_o,
  output logic [IdxW-1:0]     idx0_o,
  output logic [IdxW-1:0]     idx1_o,
  output logic [XyW-1:0]      x_o,
  output logic [XyW-1:0]      y_o,
  output logic [RcW-1:0]      rc_idx_o,
  output logic                j_wrap_o
);

  logic               access, mapped, upd;
  logic [31:0]        wr_val;
  logic               ld_m, ld_j2, ld_j, ld_idx0, ld_idx1, ld_mode, ld_x, ld_y, ld_rc;
  logic [PqctrlW-1:0] m_q, m_d, j2_q, j2_d, mode_q, mode_d, j_cnt;
  logic [IdxW-1:0]    idx0_q, idx0_d, idx1_q, idx1_d, idx1_set;
  logic [XyW-1:0]     x_cnt, y_cnt, x_ld, y_ld;
  logic [RcW-1:0]     rc_cnt, rc_ld;
  logic               j_wrap, x_wrap, y_wrap, rc_wrap;
  logic               unused_wrap;

  assign access = insn_dec_shared_i.ictrlspr_wr_insn | insn_dec_shared_i.ictrlspr_rs_insn;

  always_comb begin
    mapped       = 1'b1;
    ctrl_rdata_o = '0;
    case (ctrl_addr_i)
      PqctrlM:     ctrl_rdata_o = 32'(m_q);
      PqctrlJ2:    ctrl_rdata_o = 32'(j2_q);
      PqctrlJ:     ctrl_rdata_o = 32'(j_cnt);
      PqctrlIdx0:  ctrl_rdata_o = 32'(idx0_q);
      PqctrlIdx1:  ctrl_rdata_o = 32'(idx1_q);
      PqctrlMode:  ctrl_rdata_o = 32'(mode_q);
      PqctrlX:     ctrl_rdata_o = 32'(x_cnt);
      PqctrlY:     ctrl_rdata_o = 32'(y_cnt);
      PqctrlRcIdx: ctrl_rdata_o = 32'(rc_cnt);
      default:     mapped = 1'b0;
    endcase
  end

  assign ctrl_err_o = access & ~mapped;
  // A faulting access freezes the whole block for that cycle.
  assign upd        = commit_i & ~ctrl_err_o;
  assign wr_val     = insn_dec_shared_i.ictrlspr_rs_insn ? (ctrl_rdata_o | ctrl_wdata_i)
                                                         : ctrl_wdata_i;

  always_comb begin
    {ld_m, ld_j2, ld_j, ld_idx0, ld_idx1, ld_mode, ld_x, ld_y, ld_rc} = '0;
    if (upd && access) begin
      case (ctrl_addr_i)
        PqctrlM:     ld_m    = 1'b1;
        PqctrlJ2:    ld_j2   = 1'b1;
        PqctrlJ:     ld_j    = 1'b1;
        PqctrlIdx0:  ld_idx0 = 1'b1;
        PqctrlIdx1:  ld_idx1 = 1'b1;
        PqctrlMode:  ld_mode = 1'b1;
        PqctrlX:     ld_x    = 1'b1;
        PqctrlY:     ld_y    = 1'b1;
        PqctrlRcIdx: ld_rc   = 1'b1;
        default:     ;
      endcase
    end
  end

  // Coordinate registers can never hold out-of-range values, even via read-set.
  assign x_ld     = XyW'(wr_val % 32'(XyMod));
  assign y_ld     = XyW'(wr_val % 32'(XyMod));
  assign rc_ld    = (wr_val >= 32'(RcLimit)) ? '0 : RcW'(wr_val);
  assign idx1_set = IdxW'(j_cnt) + IdxW'(j2_q);

  always_comb begin
    m_d    = m_q;
    j2_d   = j2_q;
    mode_d = mode_q;
    idx0_d = idx0_q;
    idx1_d = idx1_q;

    if (ld_m) m_d = PqctrlW'(wr_val);
    else if (upd && insn_dec_shared_i.sl_m) m_d = m_q << 1;

    if (ld_j2) j2_d = PqctrlW'(wr_val);
    else if (upd && insn_dec_shared_i.sl_j2) j2_d = j2_q >> 1;

    if (ld_mode) mode_d = PqctrlW'(wr_val);

    if (upd && insn_dec_shared_i.set_idx) begin
      idx0_d = IdxW'(j_cnt);
      idx1_d = idx1_set;
    end
    if (upd && insn_dec_shared_i.inc_idx) begin
      idx0_d = idx0_d + IdxW'(1);
      idx1_d = idx1_d + IdxW'(1);
    end
    if (ld_idx0) idx0_d = IdxW'(wr_val);
    if (ld_idx1) idx1_d = IdxW'(wr_val);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      m_q    <= PqctrlW'(1);
      j2_q   <= '0;
      mode_q <= '0;
      idx0_q <= '0;
      idx1_q <= '0;
    end else begin
      m_q    <= m_d;
      j2_q   <= j2_d;
      mode_q <= mode_d;
      idx0_q <= idx0_d;
      idx1_q <= idx1_d;
    end
  end

  otbn_pq_mod_counter #(.Width(XyW), .Limit(XyMod), .DynLimit(1'b0)) u_x_cnt (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (ld_x),
    .load_val_i (x_ld),
    .inc_i      (upd & insn_dec_shared_i.inc_x),
    .limit_i    ('0),
    .cnt_o      (x_cnt),
    .wrap_o     (x_wrap)
  );

  otbn_pq_mod_counter #(.Width(XyW), .Limit(XyMod), .DynLimit(1'b0)) u_y_cnt (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (ld_y),
    .load_val_i (y_ld),
    .inc_i      (upd & insn_dec_shared_i.inc_y),
    .limit_i    ('0),
    .cnt_o      (y_cnt),
    .wrap_o     (y_wrap)
  );

  otbn_pq_mod_counter #(.Width(RcW), .Limit(RcLimit), .DynLimit(1'b0)) u_rc_cnt (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (ld_rc),
    .load_val_i (rc_ld),
    .inc_i      (upd & insn_dec_shared_i.rc_idx_inc),
    .limit_i    ('0),
    .cnt_o      (rc_cnt),
    .wrap_o     (rc_wrap)
  );

  // J wraps against the live J2 value; J2 = 0 therefore wraps on every increment.
  otbn_pq_mod_counter #(.Width(PqctrlW), .Limit(0), .DynLimit(1'b1)) u_j_cnt (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (ld_j),
    .load_val_i (PqctrlW'(wr_val)),
    .inc_i      (upd & insn_dec_shared_i.inc_j),
    .limit_i    (j2_q),
    .cnt_o      (j_cnt),
    .wrap_o     (j_wrap)
  );

  assign unused_wrap = ^{x_wrap, y_wrap, rc_wrap};

  assign m_o      = m_q;
  assign j2_o     = j2_q;
  assign j_o      = j_cnt;
  assign mode_o   = mode_q;
  assign idx0_o   = idx0_q;
  assign idx1_o   = idx1_q;
  assign x_o      = x_cnt;
  assign y_o      = y_cnt;
  assign rc_idx_o = rc_cnt;
  assign j_wrap_o = j_wrap;

endmodule

// File: tb/tb_otbn_pq_loop_ctrl.sv
// Scoreboard bench for otbn_pq_loop_ctrl: the driver queues expected values
// tagged with the cycle they must appear in; a negedge monitor compares them.
module tb_otbn_pq_loop_ctrl;
  import otbn_pq_pkg::*;

  localparam logic [9:0] F_SLM    = 10'h200;
  localparam logic [9:0] F_SLJ2   = 10'h100;
  localparam logic [9:0] F_INCJ   = 10'h080;
  localparam logic [9:0] F_SETIDX = 10'h040;
  localparam logic [9:0] F_INCIDX = 10'h020;
  localparam logic [9:0] F_INCX   = 10'h010;
  localparam logic [9:0] F_INCY   = 10'h008;
  localparam logic [9:0] F_RCINC  = 10'h004;
  localparam logic [9:0] F_WR     = 10'h002;
  localparam logic [9:0] F_RS     = 10'h001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_n, commit, err, j_wrap;
  insn_dec_shared_pq_t dec;
  logic [7:0]          addr, idx0, idx1;
  logic [31:0]         wdata, rdata, m, j2, j, mode;
  logic [2:0]          x, y;
  logic [4:0]          rc;

  otbn_pq_loop_ctrl #(.PqctrlW(32)) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .commit_i          (commit),
    .insn_dec_shared_i (dec),
    .ctrl_addr_i       (addr),
    .ctrl_wdata_i      (wdata),
    .ctrl_rdata_o      (rdata),
    .ctrl_err_o        (err),
    .m_o               (m),
    .j2_o              (j2),
    .j_o               (j),
    .mode_o            (mode),
    .idx0_o            (idx0),
    .idx1_o            (idx1),
    .x_o               (x),
    .y_o               (y),
    .rc_idx_o          (rc),
    .j_wrap_o          (j_wrap)
  );

  typedef enum int {S_M, S_J2, S_J, S_IDX0, S_IDX1, S_MODE, S_X, S_Y, S_RC, S_WRAP, S_RDATA, S_ERR} sig_e;
  typedef struct {
    int          cyc;
    sig_e        sig;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] get_sig(input sig_e s);
    case (s)
      S_M:     return m;
      S_J2:    return j2;
      S_J:     return j;
      S_IDX0:  return 32'(idx0);
      S_IDX1:  return 32'(idx1);
      S_MODE:  return mode;
      S_X:     return 32'(x);
      S_Y:     return 32'(y);
      S_RC:    return 32'(rc);
      S_WRAP:  return 32'(j_wrap);
      S_RDATA: return rdata;
      default: return 32'(err);
    endcase
  endfunction

  always @(negedge clk) begin
    int          i;
    logic [31:0] act;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].cyc == cyc) begin
        act = get_sig(sb[i].sig);
        n_chk++;
        if (act !== sb[i].val) begin
          n_fail++;
          $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", sb[i].name, act, sb[i].val, cyc);
        end
        sb.delete(i);
      end else if (sb[i].cyc < cyc) begin
        n_chk++;
        n_fail++;
        $display("FAIL %s: never sampled, expected 0x%0h at cycle %0d", sb[i].name, sb[i].val, sb[i].cyc);
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic step(input logic [9:0] f, input logic [7:0] a, input logic [31:0] d,
                      input logic c, input logic r);
    @(posedge clk);
    #1;
    dec    = insn_dec_shared_pq_t'(f);
    addr   = a;
    wdata  = d;
    commit = c;
    rst_n  = r;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    step(F_WR, a, d, 1'b1, 1'b1);
  endtask

  task automatic idle();
    step(10'h000, 8'h00, 32'h0, 1'b0, 1'b1);
  endtask

  // dly = 0: combinational result of this cycle's inputs; dly = 1: registered result.
  task automatic expect_at(input int dly, input sig_e s, input logic [31:0] v, input string n);
    exp_t e;
    e.cyc  = cyc + dly;
    e.sig  = s;
    e.val  = v;
    e.name = n;
    sb.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    commit = 1'b0;
    dec    = '0;
    addr   = '0;
    wdata  = '0;
    step(10'h000, 8'h00, 32'h0, 1'b1, 1'b0);
    step(10'h000, 8'h00, 32'h0, 1'b1, 1'b0);

    idle();
    expect_at(0, S_M,    32'h1, "rst_m");
    expect_at(0, S_J2,   32'h0, "rst_j2");
    expect_at(0, S_J,    32'h0, "rst_j");
    expect_at(0, S_IDX0, 32'h0, "rst_idx0");
    expect_at(0, S_IDX1, 32'h0, "rst_idx1");
    expect_at(0, S_MODE, 32'h0, "rst_mode");
    expect_at(0, S_X,    32'h0, "rst_x");
    expect_at(0, S_Y,    32'h0, "rst_y");
    expect_at(0, S_RC,   32'h0, "rst_rc");
    expect_at(0, S_WRAP, 32'h0, "rst_wrap");

    // J counts 1,2,3,0 against J2=4; pulse only after the 4th increment
    wr(PqctrlJ2, 32'd4);
    expect_at(1, S_J2, 32'd4, "wr_j2");
    for (int i = 1; i <= 4; i++) begin
      step(F_INCJ, 8'h00, 32'h0, 1'b1, 1'b1);
      expect_at(1, S_J,    32'(i % 4),  "j_seq");
      expect_at(1, S_WRAP, 32'(i == 4), "j_wrap_seq");
    end
    idle();
    expect_at(1, S_WRAP, 32'h0, "j_wrap_single");

    // set_idx then inc_idx in the same instruction
    wr(PqctrlJ, 32'd3);
    wr(PqctrlJ2, 32'd8);
    step(F_SETIDX | F_INCIDX, 8'h00, 32'h0, 1'b1, 1'b1);
    expect_at(1, S_IDX0, 32'd4,  "set_inc_idx0");
    expect_at(1, S_IDX1, 32'd12, "set_inc_idx1");
    wr(PqctrlIdx0, 32'd255);
    step(F_INCIDX, 8'h00, 32'h0, 1'b1, 1'b1);
    expect_at(1, S_IDX0, 32'd0,  "idx0_mod256");
    expect_at(1, S_IDX1, 32'd13, "idx1_inc");
    step(10'h000, PqctrlIdx1, 32'h0, 1'b0, 1'b1);
    expect_at(0, S_RDATA, 32'd13, "rd_idx1");

    // Keccak coordinates and round-constant index
    wr(PqctrlY, 32'd4);
    step(F_INCX | F_INCY, 8'h00, 32'h0, 1'b1, 1'b1);
    expect_at(1, S_X, 32'd1, "inc_x");
    expect_at(1, S_Y, 32'd0, "inc_y_wrap");
    wr(PqctrlX, 32'd7);
    expect_at(1, S_X, 32'd2, "wr_x_mod5");
    wr(PqctrlRcIdx, 32'd23);
    expect_at(1, S_RC, 32'd23, "wr_rc");
    step(F_RCINC, 8'h00, 32'h0, 1'b1, 1'b1);
    expect_at(1, S_RC, 32'd0, "rc_wrap");
    wr(PqctrlRcIdx, 32'd10);
    expect_at(1, S_RC, 32'd10, "wr_rc10");
    wr(PqctrlRcIdx, 32'd30);
    expect_at(1, S_RC, 32'd0, "wr_rc_oor");

    // read-set on Mode, then an unmapped write
    wr(PqctrlMode, 32'h5);
    step(F_RS, PqctrlMode, 32'hA, 1'b1, 1'b1);
    expect_at(0, S_RDATA, 32'h5, "rs_old");
    expect_at(0, S_ERR,   32'h0, "rs_no_err");
    expect_at(1, S_MODE,  32'hF, "rs_new");
    step(F_WR, 8'h10, 32'hFFFF, 1'b1, 1'b1);
    expect_at(0, S_ERR,   32'h1,  "err_unmapped");
    expect_at(0, S_RDATA, 32'h0,  "rd_unmapped");
    expect_at(1, S_MODE,  32'hF,  "err_mode_kept");
    expect_at(1, S_X,     32'd2,  "err_x_kept");

    // write beats increment on J; other registers still update
    step(F_WR | F_INCJ, PqctrlJ, 32'd2, 1'b1, 1'b1);
    expect_at(1, S_J,    32'd2, "wr_over_inc_j");
    expect_at(1, S_WRAP, 32'h0, "wr_over_inc_nowrap");
    step(F_WR | F_INCX, PqctrlY, 32'd3, 1'b1, 1'b1);
    expect_at(1, S_Y, 32'd3, "wr_y");
    expect_at(1, S_X, 32'd3, "inc_x_parallel");
    wr(PqctrlM, 32'h8000_0000);
    step(F_SLM, 8'h00, 32'h0, 1'b1, 1'b1);
    expect_at(1, S_M, 32'h0, "sl_m_msb_drop");
    step(F_SLJ2, 8'h00, 32'h0, 1'b1, 1'b1);
    expect_at(1, S_J2, 32'd4, "sl_j2");
    step(F_INCJ | F_SLJ2, 8'h00, 32'h0, 1'b0, 1'b1);
    expect_at(1, S_J,  32'd2, "nocommit_j");
    expect_at(1, S_J2, 32'd4, "nocommit_j2");

    // J2 = 0 wraps on the first increment
    wr(PqctrlJ2, 32'd0);
    step(F_INCJ, 8'h00, 32'h0, 1'b1, 1'b1);
    expect_at(1, S_J,    32'd0, "j2_zero_j");
    expect_at(1, S_WRAP, 32'h1, "j2_zero_wrap");
    idle();
    expect_at(1, S_WRAP, 32'h0, "j2_zero_wrap_end");

    // reset with commit high and a wrap about to be generated
    wr(PqctrlM, 32'h1234);
    wr(PqctrlJ, 32'd5);
    step(F_INCJ | F_INCX | F_SLM | F_SETIDX, 8'h00, 32'h0, 1'b1, 1'b0);
    expect_at(1, S_M,    32'h1, "mid_rst_m");
    expect_at(1, S_J,    32'h0, "mid_rst_j");
    expect_at(1, S_J2,   32'h0, "mid_rst_j2");
    expect_at(1, S_IDX1, 32'h0, "mid_rst_idx1");
    expect_at(1, S_MODE, 32'h0, "mid_rst_mode");
    expect_at(1, S_X,    32'h0, "mid_rst_x");
    expect_at(1, S_Y,    32'h0, "mid_rst_y");
    expect_at(1, S_WRAP, 32'h0, "mid_rst_wrap");
    idle();
    expect_at(1, S_WRAP, 32'h0, "post_rst_wrap");

    repeat (3) idle();
    while (sb.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: left unchecked, expected 0x%0h", sb[0].name, sb[0].val);
      sb.delete(0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/otbn_pq_loop_ctrl.md
OTBN_PQ_LOOP_CTRL -- requirements
Module: otbn_pq_loop_ctrl

Interface
REQ-001 SHALL have parameter PqctrlW, default 32, meaning the width of the M, J2, J and Mode registers and of the read/write data.
REQ-002 SHALL have the ports listed below, clock and reset first:
- clk_i  in  1  single clock.
- rst_ni  in  1  reset, synchronous and active-low.
- commit_i  in  1  the instruction retires this cycle; all updates are gated by it.
- insn_dec_shared_i  in  insn_dec_shared_pq_t  decoded control flags: sl_m, sl_j2, inc_j, set_idx, inc_idx, inc_x, inc_y, rc_idx_inc, ictrlspr_wr_insn, ictrlspr_rs_insn.
- ctrl_addr_i  in  8  pqctrlspr_e address.
- ctrl_wdata_i  in  32  write or set data.
- ctrl_rdata_o  out  32  combinational read data.
- ctrl_err_o  out  1  unmapped address on a valid access.
- m_o, j2_o, j_o, mode_o  out  32 each  register values.
- idx0_o, idx1_o  out  8 each  {WDR[4:0], word[2:0]} indices.
- x_o, y_o  out  3 each  Keccak lane coordinates.
- rc_idx_o  out  5  round-constant index.
- j_wrap_o  out  1  registered one-cycle pulse on J wrap.

Function
REQ-003 SHALL own only the addresses M, J2, J, Idx0, Idx1, Mode, X, Y and RcIdx; every other address SHALL read 0 and, when accessed, SHALL assert ctrl_err_o combinationally.
REQ-004 SHALL make no state change while commit_i=0.
REQ-005 SHALL apply the following updates when commit_i=1 and the named flag is set:
- sl_m: M <= M<<1; the MSB is dropped.
- sl_j2: J2 <= J2>>1.
- inc_j: J <= J+1; if J+1 >= J2, then J <= 0 and j_wrap_o=1 in the next cycle.
- set_idx: Idx0 <= J[7:0]; Idx1 <= (J+J2)[7:0].
- inc_idx: Idx0 and Idx1 each +1, modulo 256.
- inc_x: X <= (X==4) ? 0 : X+1.
- inc_y: Y <= (Y==4) ? 0 : Y+1.
- rc_idx_inc: RcIdx <= (RcIdx==23) ? 0 : RcIdx+1.
REQ-006 SHALL, when set_idx and inc_idx are both set, take the set_idx result first and then add 1.
REQ-007 SHALL, on a write (ictrlspr_wr_insn), load the addressed register with ctrl_wdata_i truncated to the register width; X and Y SHALL be loaded with wdata mod 5, and RcIdx with 0 if wdata >= 24.
REQ-008 SHALL, on a read-set (ictrlspr_rs_insn), return the old value on ctrl_rdata_o and write old | wdata to the register.
REQ-009 SHALL give an explicit write or set precedence over any increment or shift on the same register in the same cycle; updates to other registers SHALL proceed normally.
REQ-010 SHALL drive j_wrap_o high for exactly one cycle per wrap and low otherwise.
REQ-011 SHALL make no register update on an access flagged by ctrl_err_o.
REQ-012 SHALL, when J2=0 and inc_j is set, wrap immediately (J <= 0, pulse).
REQ-013 SHALL read each register zero-extended to 32 bits.

Reset
REQ-014 SHALL, with rst_ni low at a clock edge, reset M=1, J2=0, J=0, Idx0=0, Idx1=0, Mode=0, X=0, Y=0, RcIdx=0 and j_wrap_o=0.
REQ-015 SHALL let reset override commit_i in the same cycle and discard any in-flight wrap pulse.

Structure
REQ-016 SHALL place the X/Y modulus (5), the RcIdx limit (24) and the Idx width (8) as constants in otbn_pq_pkg, alongside pqctrlspr_e.
REQ-017 SHALL instantiate one sub-module, otbn_pq_mod_counter (parameterised width and limit, with load, increment and wrap pulse), for each of X, Y, RcIdx and J.

Verification
REQ-018 SHALL cover: J2=4, four inc_j commits -> J sequence 1,2,3,0 and j_wrap_o high only in the cycle after the 4th.
REQ-019 SHALL cover: J=3, J2=8, set_idx+inc_idx -> Idx0=4, Idx1=12; Idx0=255 with inc_idx -> 0.
REQ-020 SHALL cover: Y=4 with inc_x+inc_y -> X=1 (from 0), Y=0; write X=7 -> X=2.
REQ-021 SHALL cover: rs to Mode with Mode=0x5 and wdata=0xA -> rdata=0x5, then Mode=0xF; write to 0x10 -> ctrl_err_o=1 and no change.
REQ-022 SHALL cover: a write to J=2 in the same cycle as inc_j -> J=2; sl_m with M=0x80000000 -> M=0.
REQ-023 SHALL cover: rst_ni low mid-sequence, with commit_i high -> all registers at reset values next cycle and j_wrap_o=0.
